wb_stage_reg: RTL and testbench
===============================

// Module: wb_stage_reg
// PURPOSE
//  Parametrised MEM->WB pipeline register, successor of the fixed single-lane MEM/WB latch.
//  Carries LANES writeback lanes (rd_addr, rd_data, rd_we) with a valid/ready handshake.
//  Optional 2-entry skid buffer gives full throughput with a registered in_ready.
//  Adds flush and occupancy reporting. Sits between MEM and WB; WB may backpressure via out_ready.
// PARAMETERS
//  DATA_W   32  width of rd_data per lane
//  ADDR_W   5   width of rd_addr per lane
//  LANES    1   number of writeback lanes carried per beat (1..4)
//  SKID     1   1: 2-entry skid, in_ready registered; 0: single entry, in_ready combinational
// PORTS
//  clk         in   1              clock, all state updates on rising edge
//  rst         in   1              synchronous reset, active-high
//  flush       in   1              discard all held and incoming beats this cycle
//  in_valid    in   1              MEM presents a beat
//  in_ready    out  1              stage can accept a beat this cycle
//  in_rd_addr  in   LANES*ADDR_W   lane i at [i*ADDR_W +: ADDR_W]
//  in_rd_data  in   LANES*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  in_rd_we    in   LANES          per-lane write enable
//  out_valid   out  1              beat presented to WB
//  out_ready   in   1              WB consumes beat this cycle
//  out_rd_addr out  LANES*ADDR_W   held beat, main slot
//  out_rd_data out  LANES*DATA_W   held beat, main slot
//  out_rd_we   out  LANES          held beat, main slot, already x0-filtered
//  occupancy   out  2              beats held: 0..2 (0..1 when SKID=0)
// BEHAVIOUR
//  - Reset (rst=1 at edge): both slot valids 0, all payload regs 0; out_valid=0, out_*=0,
//    occupancy=0; in_ready=1 in the first cycle after reset. Reset overrides flush and handshakes.
//  - accept = in_valid & in_ready; emit = out_valid & out_ready. Latency in->out: 1 cycle.
//  - x0 rule: on accept, lane we stored as in_rd_we[i] & (in_rd_addr[i] != 0). rd_addr/rd_data stored unchanged.
//  - SKID=1: slots MAIN (drives out_*) and SKID. in_ready = ~skid_valid (pure flop output).
//      accept & (~main_valid | emit)      -> beat into MAIN.
//      accept & main_valid & ~emit        -> beat into SKID.
//      emit & skid_valid                  -> SKID moves to MAIN, skid_valid<=0.
//      emit & skid_valid & accept cannot occur (in_ready=0 while skid full).
//      emit & ~skid_valid & ~accept       -> main_valid<=0.
//  - SKID=0: single MAIN slot; in_ready = ~main_valid | out_ready (combinational).
//  - Ordering: beats leave in acceptance order; no beat duplicated or dropped except by flush.
//  - flush=1: both valids <=0 next cycle; incoming beat dropped even if accept; in_ready
//    unaffected this cycle. out_* payload may retain stale values; only out_valid is normative.
//  - When out_valid=1 & out_ready=0, out_* must hold stable until emit or flush.
//  - occupancy = main_valid + skid_valid, registered.
//  - Invariant: skid_valid=1 implies main_valid=1; assert in bench.
// STRUCTURE
//  - Package types: add WB_LANES_MAX=4 and REG_ZERO='0 (ADDR_W-wide); keep wb_params_t as
//    single-lane view. Per-lane slices via localparams inside the module, no parametrised typedefs.
//  - One sub-module: wb_slot (valid flop + payload regs, load/clear/hold inputs, sync reset),
//    instantiated twice when SKID=1, once when SKID=0. Control logic stays in wb_stage_reg.
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, occupancy=0, out_*=0; in_ready=1 after.
//  2 Streaming, out_ready=1: 8 beats rd_addr=1..8, data=0xA0+n, we=1 back-to-back -> same 8 beats
//    out one cycle later, no bubbles, occupancy never exceeds 1.
//  3 Backpressure SKID=1: send beats 0x11,0x22,0x33 with out_ready=0 -> 0x11 held, 0x22 in skid,
//    in_ready=0 from cycle 3, occupancy=2; raise out_ready -> 0x11,0x22,0x33 emitted in order.
//  4 x0 filter LANES=2: lane0 addr=0 we=1 data=0xDEAD, lane1 addr=3 we=1 -> out_rd_we=2'b10, data passed.
//  5 Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, occupancy=0,
//    flushed beats never appear; following beat 0x44 emits normally.
//  6 SKID=0: out_ready=0 with main full -> in_ready=0 same cycle; out_ready=1 -> accept and emit same cycle.

Source files
------------

// File: rtl/wb_stage_reg_pkg.sv
// wb_stage_reg_pkg
//   Shared constants and types for the MEM->WB writeback stage register.
//   WB_LANES_MAX : upper bound on writeback lanes carried per beat
//   REG_ZERO     : architectural x0 register index; writes to it are squashed
//   wb_params_t  : single-lane view of one writeback (rd_addr, rd_data, rd_we)
package wb_stage_reg_pkg;

  localparam int WB_DATA_W    = 32;
  localparam int WB_ADDR_W    = 5;
  localparam int WB_LANES_MAX = 4;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd_addr;
    logic [WB_DATA_W-1:0] rd_data;
    logic                 rd_we;
  } wb_params_t;

endpackage

// File: rtl/wb_stage_reg_slot.sv
// wb_slot
//   One storage slot of the writeback stage: a valid flop plus payload register.
//   clk, rst : clock and synchronous active-high reset (valid and payload to 0)
//   load     : capture d and set valid
//   clear    : drop valid; payload is left as-is (stale payload is harmless)
//   d        : payload to capture
//   valid, q : slot state
//   Neither load nor clear asserted holds the slot. clear wins over load.
module wb_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/wb_stage_reg.sv
// wb_stage_reg
//   Parametrised MEM->WB pipeline register carrying LANES writeback lanes per beat
//   with a valid/ready handshake, flush and occupancy reporting.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop every held beat and any beat arriving this cycle
//   in_valid/ready  : upstream handshake (MEM side)
//   in_rd_*         : incoming beat, lane i at [i*W +: W]
//   out_valid/ready : downstream handshake (WB side)
//   out_rd_*        : beat in the MAIN slot; rd_we already has x0 writes removed
//   occupancy       : number of beats held (0..2, or 0..1 without skid)
//   SKID=1 keeps a second slot so in_ready can come straight from a flop;
//   SKID=0 uses a single slot with a combinational in_ready.
module wb_stage_reg
  import wb_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ADDR_W-1:0] in_rd_addr,
  input  logic [LANES*DATA_W-1:0] in_rd_data,
  input  logic [LANES-1:0]        in_rd_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ADDR_W-1:0] out_rd_addr,
  output logic [LANES*DATA_W-1:0] out_rd_data,
  output logic [LANES-1:0]        out_rd_we,
  output logic [1:0]              occupancy
);

  localparam int ADDR_BUS_W = LANES * ADDR_W;
  localparam int DATA_BUS_W = LANES * DATA_W;
  localparam int BEAT_W     = ADDR_BUS_W + DATA_BUS_W + LANES;
  localparam int DATA_LSB   = ADDR_BUS_W;
  localparam int WE_LSB     = ADDR_BUS_W + DATA_BUS_W;

  logic [LANES-1:0]  in_we_filt;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] main_d;
  logic [BEAT_W-1:0] main_q;
  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic              main_nxt;
  logic              skid_valid;
  logic              skid_nxt;
  logic              accept;
  logic              emit;
  logic [1:0]        occ_q;

  // Writes targeting x0 are squashed once, on entry, so both slots hold clean beats.
  always_comb begin
    in_we_filt = '0;
    for (int i = 0; i < LANES; i++) begin
      in_we_filt[i] = in_rd_we[i] & (in_rd_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
    end
  end

  assign in_beat = {in_we_filt, in_rd_data, in_rd_addr};
  assign accept  = in_valid & in_ready;
  assign emit    = main_valid & out_ready;

  wb_slot #(.W(BEAT_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_load;
      logic              skid_clear;
      logic [BEAT_W-1:0] skid_q;

      wb_slot #(.W(BEAT_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_beat),
        .valid (skid_valid),
        .q     (skid_q)
      );

      // A full skid slot blocks input, so accept never coincides with a skid->main move.
      assign in_ready   = ~skid_valid;
      assign skid_load  = ~flush & accept & main_valid & ~emit;
      assign skid_clear = flush | (emit & skid_valid);
      assign main_load  = ~flush & ((emit & skid_valid) | (accept & (~main_valid | emit)));
      assign main_clear = flush | (emit & ~skid_valid & ~accept);
      assign main_d     = skid_valid ? skid_q : in_beat;
      assign skid_nxt   = ~skid_clear & (skid_load | skid_valid);
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_nxt   = 1'b0;
      assign in_ready   = ~main_valid | out_ready;
      assign main_load  = ~flush & accept;
      assign main_clear = flush | (emit & ~accept);
      assign main_d     = in_beat;
    end
  endgenerate

  // Mirrors the slot update priority (clear over load) to get next-cycle valids.
  assign main_nxt = ~main_clear & (main_load | main_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= {1'b0, main_nxt} + {1'b0, skid_nxt};
    end
  end

  assign occupancy   = occ_q;
  assign out_valid   = main_valid;
  assign out_rd_addr = main_q[0 +: ADDR_BUS_W];
  assign out_rd_data = main_q[DATA_LSB +: DATA_BUS_W];
  assign out_rd_we   = main_q[WE_LSB +: LANES];

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
    logic [1:0]  we;
  } beat_t;

  typedef struct packed {
    logic        iv;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic [31:0] e_dout;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [9:0]  in_addr;
  logic [63:0] in_data;
  logic [1:0]  in_we;

  logic        in_valid_a, out_ready_a, in_ready_a, out_valid_a;
  logic [9:0]  out_addr_a;
  logic [63:0] out_data_a;
  logic [1:0]  out_we_a;
  logic [1:0]  occ_a;

  logic        in_valid_b, out_ready_b, in_ready_b, out_valid_b;
  logic [9:0]  out_addr_b;
  logic [63:0] out_data_b;
  logic [1:0]  out_we_b;
  logic [1:0]  occ_b;

  beat_t qa[$];
  beat_t qb[$];
  vec_t  tbl[15];

  always #5 clk = ~clk;

  wb_stage_reg #(.DATA_W(32), .ADDR_W(5), .LANES(2), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_rd_addr(in_addr), .in_rd_data(in_data), .in_rd_we(in_we),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_rd_addr(out_addr_a), .out_rd_data(out_data_a), .out_rd_we(out_we_a),
    .occupancy(occ_a)
  );

  wb_stage_reg #(.DATA_W(32), .ADDR_W(5), .LANES(2), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_rd_addr(in_addr), .in_rd_data(in_data), .in_rd_we(in_we),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_rd_addr(out_addr_b), .out_rd_data(out_data_b), .out_rd_we(out_we_b),
    .occupancy(occ_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [9:0] a, input logic [63:0] d, input logic [1:0] w);
    beat_t b;
    b.addr = a;
    b.data = d;
    for (int i = 0; i < 2; i++) b.we[i] = w[i] && (a[i*5 +: 5] != 5'd0);
    return b;
  endfunction

  // Scoreboard for the skid instance: queue depth is the expected occupancy.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      chk("a_occ", 64'(occ_a), 64'(qa.size()));
      chk("a_in_ready", 64'(in_ready_a), 64'(qa.size() < 2));
      chk("a_out_valid", 64'(out_valid_a), 64'(qa.size() != 0));
      checks++;
      assert (!dut_a.skid_valid || dut_a.main_valid)
      else begin
        failures++;
        $display("FAIL a_skid_invariant actual=skid_valid without main_valid at %0t", $time);
      end
      if (out_valid_a && qa.size() != 0) begin
        chk("a_out_addr", 64'(out_addr_a), 64'(qa[0].addr));
        chk("a_out_data", out_data_a, qa[0].data);
        chk("a_out_we", 64'(out_we_a), 64'(qa[0].we));
      end
      if (flush) begin
        qa.delete();
      end else begin
        if (out_valid_a && out_ready_a && qa.size() != 0) void'(qa.pop_front());
        if (in_valid_a && in_ready_a) qa.push_back(mk(in_addr, in_data, in_we));
      end
    end
  end

  // Scoreboard for the single-slot instance.
  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      chk("b_occ", 64'(occ_b), 64'(qb.size()));
      chk("b_in_ready", 64'(in_ready_b), 64'((qb.size() == 0) || out_ready_b));
      chk("b_out_valid", 64'(out_valid_b), 64'(qb.size() != 0));
      if (out_valid_b && qb.size() != 0) begin
        chk("b_out_addr", 64'(out_addr_b), 64'(qb[0].addr));
        chk("b_out_data", out_data_b, qb[0].data);
        chk("b_out_we", 64'(out_we_b), 64'(qb[0].we));
      end
      if (flush) begin
        qb.delete();
      end else begin
        if (out_valid_b && out_ready_b && qb.size() != 0) void'(qb.pop_front());
        if (in_valid_b && in_ready_b) qb.push_back(mk(in_addr, in_data, in_we));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [31:0] d);
    in_addr = {5'd0, a};
    in_data = {32'h0, d};
    in_we   = 2'b01;
  endtask

  initial begin
    // in_valid | addr | data | out_ready | flush || in_ready | out_valid | occ | out data
    tbl[0]  = '{1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
    tbl[2]  = '{1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h11};
    tbl[3]  = '{1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h11};
    tbl[4]  = '{1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h22};
    tbl[5]  = '{1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h33};
    tbl[6]  = '{1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[7]  = '{1'b1, 5'd5, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[8]  = '{1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h55};
    tbl[9]  = '{1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h55};
    tbl[10] = '{1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h44};
    tbl[12] = '{1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[13] = '{1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[14] = '{1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};

    rst = 1'b1;
    flush = 1'b0;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    drive(5'd9, 32'hFFFF);

    // Reset held three edges with traffic offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid_a", 64'(out_valid_a), 64'(0));
    chk("rst_occ_a", 64'(occ_a), 64'(0));
    chk("rst_out_addr_a", 64'(out_addr_a), 64'(0));
    chk("rst_out_data_a", out_data_a, 64'(0));
    chk("rst_out_we_a", 64'(out_we_a), 64'(0));
    chk("rst_out_valid_b", 64'(out_valid_b), 64'(0));
    chk("rst_occ_b", 64'(occ_b), 64'(0));
    next_cycle();
    rst = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_a", 64'(in_ready_a), 64'(1));
    chk("post_rst_in_ready_b", 64'(in_ready_b), 64'(1));
    next_cycle();

    // Back-to-back streaming with WB always ready.
    out_ready_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      in_valid_a = (k <= 8);
      drive(5'(k), 32'hA0 + 32'(k));
      @(negedge clk);
      if (k >= 2) begin
        chk("stream_out_valid", 64'(out_valid_a), 64'(1));
        chk("stream_out_data", out_data_a, 64'(32'hA0 + 32'(k - 1)));
        chk("stream_occ", 64'(occ_a), 64'(1));
      end
      next_cycle();
    end

    // x0 squash on lane 0, lane 1 untouched.
    in_valid_a = 1'b1;
    in_addr = {5'd3, 5'd0};
    in_data = {32'hBEEF, 32'hDEAD};
    in_we = 2'b11;
    next_cycle();
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("x0_out_we", 64'(out_we_a), 64'(2'b10));
    chk("x0_out_data", out_data_a, {32'hBEEF, 32'hDEAD});
    chk("x0_out_addr", 64'(out_addr_a), 64'({5'd3, 5'd0}));
    next_cycle();

    // Backpressure, skid fill/drain and flush.
    for (int i = 0; i < 15; i++) begin
      in_valid_a = tbl[i].iv;
      out_ready_a = tbl[i].ordy;
      flush = tbl[i].fl;
      drive(tbl[i].addr, tbl[i].data);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready_a), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid_a), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occ", i), 64'(occ_a), 64'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data_a, 64'(tbl[i].e_dout));
      next_cycle();
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    flush = 1'b0;

    // Single-slot variant: combinational in_ready, accept and emit in one cycle.
    in_valid_b = 1'b1;
    out_ready_b = 1'b0;
    drive(5'd1, 32'h11);
    @(negedge clk);
    chk("b_empty_in_ready", 64'(in_ready_b), 64'(1));
    next_cycle();
    drive(5'd2, 32'h22);
    @(negedge clk);
    chk("b_full_in_ready", 64'(in_ready_b), 64'(0));
    chk("b_full_out_data", out_data_b, 64'(32'h11));
    next_cycle();
    out_ready_b = 1'b1;
    @(negedge clk);
    chk("b_pass_in_ready", 64'(in_ready_b), 64'(1));
    chk("b_pass_out_data", out_data_b, 64'(32'h11));
    next_cycle();
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("b_second_valid", 64'(out_valid_b), 64'(1));
    chk("b_second_data", out_data_b, 64'(32'h22));
    next_cycle();
    out_ready_b = 1'b0;
    @(negedge clk);
    chk("b_drained_valid", 64'(out_valid_b), 64'(0));
    chk("b_drained_occ", 64'(occ_b), 64'(0));

    repeat (2) next_cycle();
    chk("a_queue_empty", 64'(qa.size()), 64'(0));
    chk("b_queue_empty", 64'(qb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
